// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the D pipeline register bundle.
package y86_pkg;

   localparam int unsigned XLEN = 64;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef struct packed {
      logic [2:0]      stat;
      logic [3:0]      icode;
      logic [3:0]      ifun;
      logic [3:0]      ra;
      logic [3:0]      rb;
      logic [XLEN-1:0] valc;
      logic [XLEN-1:0] valp;
   } d_reg_t;

   localparam d_reg_t D_BUBBLE = '{
      stat:  STAT_AOK,
      icode: I_NOP,
      ifun:  4'h0,
      ra:    RNONE,
      rb:    RNONE,
      valc:  64'd0,
      valp:  64'd0
   };

   // Memory fault outranks an illegal opcode, which outranks halt.
   function automatic logic [2:0] fetch_stat(input logic       mem_err,
                                             input logic       valid,
                                             input logic [3:0] icode);
      logic [2:0] stat;
      if (mem_err) begin
         stat = STAT_ADR;
      end else if (!valid) begin
         stat = STAT_INS;
      end else if (icode == I_HALT) begin
         stat = STAT_HLT;
      end else begin
         stat = STAT_AOK;
      end
      return stat;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port: fetch address out, 10-byte window and fault flag back.
interface fetch_stage_if #(
   parameter int unsigned ADDR_W = 64
);
   logic [ADDR_W-1:0] imem_addr;
   logic [79:0]       imem_data;
   logic              imem_error;

   modport master (output imem_addr, input imem_data, input imem_error);
   modport slave  (input imem_addr, output imem_data, output imem_error);
endinterface

// File: rtl/fetch_stage_instr_split.sv
// Combinational splitter of a 10-byte instruction window into Y86-64 fields.
module instr_split
   import y86_pkg::*;
(
   input  logic [79:0] byte_stream_i,
   output logic [3:0]  icode_o,
   output logic [3:0]  ifun_o,
   output logic [3:0]  ra_o,
   output logic [3:0]  rb_o,
   output logic [63:0] valc_o,
   output logic        need_regids_o,
   output logic        need_valc_o,
   output logic        instr_valid_o
);

   assign icode_o = byte_stream_i[7:4];
   assign ifun_o  = byte_stream_i[3:0];

   // Per-opcode format: legal range, register byte present, constant present.
   always_comb begin
      instr_valid_o = 1'b1;
      need_regids_o = 1'b0;
      need_valc_o   = 1'b0;
      case (icode_o)
         I_HALT, I_NOP, I_RET: begin
            need_regids_o = 1'b0;
            need_valc_o   = 1'b0;
         end
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
            need_regids_o = 1'b1;
            need_valc_o   = 1'b0;
         end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            need_regids_o = 1'b1;
            need_valc_o   = 1'b1;
         end
         I_JXX, I_CALL: begin
            need_regids_o = 1'b0;
            need_valc_o   = 1'b1;
         end
         default: begin
            instr_valid_o = 1'b0;
            need_regids_o = 1'b0;
            need_valc_o   = 1'b0;
         end
      endcase
   end

   // The constant starts right after the register byte when one is present.
   always_comb begin
      ra_o   = RNONE;
      rb_o   = RNONE;
      valc_o = 64'd0;
      if (need_regids_o) begin
         ra_o = byte_stream_i[15:12];
         rb_o = byte_stream_i[11:8];
      end else begin
         ra_o = RNONE;
         rb_o = RNONE;
      end
      if (need_valc_o && need_regids_o) begin
         valc_o = byte_stream_i[79:16];
      end else if (need_valc_o) begin
         valc_o = byte_stream_i[71:8];
      end else begin
         valc_o = 64'd0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, decode, next-PC prediction, F and D pipeline registers.
module fetch_stage
   import y86_pkg::*;
#(
   parameter int unsigned ADDR_W = 64
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              F_stall,
   input  logic              D_stall,
   input  logic              D_bubble,
   input  logic [3:0]        M_icode,
   input  logic              M_cnd,
   input  logic [ADDR_W-1:0] M_valA,
   input  logic [3:0]        W_icode,
   input  logic [ADDR_W-1:0] W_valM,
   fetch_stage_if.master     imem,
   output logic [2:0]        D_stat,
   output logic [3:0]        D_icode,
   output logic [3:0]        D_ifun,
   output logic [3:0]        D_rA,
   output logic [3:0]        D_rB,
   output logic [ADDR_W-1:0] D_valC,
   output logic [ADDR_W-1:0] D_valP,
   output logic [ADDR_W-1:0] f_predPC
);

   logic [ADDR_W-1:0] f_pred_q, f_pred_d;
   d_reg_t            d_q, d_d;
   logic [ADDR_W-1:0] f_pc_s;
   logic [ADDR_W-1:0] f_valp_s;
   logic [79:0]       split_in_s;
   logic [3:0]        f_icode_s, f_ifun_s, f_ra_s, f_rb_s;
   logic [63:0]       f_valc_s;
   logic              need_regids_s, need_valc_s, instr_valid_s;

   // Late-resolved control flow overrides the prediction; a mispredict in M outranks ret in W.
   always_comb begin
      f_pc_s = f_pred_q;
      if ((M_icode == I_JXX) && !M_cnd) begin
         f_pc_s = M_valA;
      end else if (W_icode == I_RET) begin
         f_pc_s = W_valM;
      end else begin
         f_pc_s = f_pred_q;
      end
   end

   assign imem.imem_addr = f_pc_s;

   // A faulting fetch is decoded as a nop so no register or constant bytes are consumed.
   assign split_in_s = {imem.imem_data[79:8],
                        imem.imem_error ? {I_NOP, 4'h0} : imem.imem_data[7:0]};

   instr_split u_split (
      .byte_stream_i (split_in_s),
      .icode_o       (f_icode_s),
      .ifun_o        (f_ifun_s),
      .ra_o          (f_ra_s),
      .rb_o          (f_rb_s),
      .valc_o        (f_valc_s),
      .need_regids_o (need_regids_s),
      .need_valc_o   (need_valc_s),
      .instr_valid_o (instr_valid_s)
   );

   assign f_valp_s = f_pc_s + 64'd1 + {63'd0, need_regids_s} + (need_valc_s ? 64'd8 : 64'd0);

   // Next-PC prediction and D-register next state.
   always_comb begin
      f_pred_d = f_valp_s;
      d_d      = d_q;
      if ((f_icode_s == I_JXX) || (f_icode_s == I_CALL)) begin
         f_pred_d = f_valc_s;
      end else begin
         f_pred_d = f_valp_s;
      end
      if (D_stall) begin
         d_d = d_q;
      end else if (D_bubble) begin
         d_d = D_BUBBLE;
      end else begin
         d_d.stat  = fetch_stat(imem.imem_error, instr_valid_s, f_icode_s);
         d_d.icode = f_icode_s;
         d_d.ifun  = f_ifun_s;
         d_d.ra    = f_ra_s;
         d_d.rb    = f_rb_s;
         d_d.valc  = f_valc_s;
         d_d.valp  = f_valp_s;
      end
   end

   // F and D pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_pred_q <= 64'd0;
         d_q      <= D_BUBBLE;
      end else begin
         if (!F_stall) begin
            f_pred_q <= f_pred_d;
         end else begin
            f_pred_q <= f_pred_q;
         end
         d_q <= d_d;
      end
   end

   assign D_stat   = d_q.stat;
   assign D_icode  = d_q.icode;
   assign D_ifun   = d_q.ifun;
   assign D_rA     = d_q.ra;
   assign D_rB     = d_q.rb;
   assign D_valC   = d_q.valc;
   assign D_valP   = d_q.valp;
   assign f_predPC = f_pred_q;

endmodule
